serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_pkg.sv | 13 +
 rtl/serial_add_ctrl_if.sv | 32 +++
 rtl/serial_add_ctrl_fa.sv | 43 ++++
 rtl/serial_add_ctrl.sv | 96 +++++++++
 tb/tb_serial_add_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_add_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a consumer and serial_add_ctrl.
// The consumer owns the master side, the controller the slave side.
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             abort;
  logic             ack;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             c_out;

  modport master (
    output start, a_in, b_in, c_in,
    output abort, ack,
    input  busy, done, sum_out, c_out
  );

  modport slave (
    input  start, a_in, b_in, c_in,
    input  abort, ack,
    output busy, done, sum_out, c_out
  );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Half-adder based 1-bit full adder cell.
// Two half adders chained, carries merged with an OR.
module halfadder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s1;
  logic c1;
  logic c2;

  halfadder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s1),
    .c_o (c1)
  );

  halfadder u_ha1 (
    .a_i (s1),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c2)
  );

  assign c_o = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: LSB first, one bit per clock through a
// single full-adder cell, with start/abort/ack control FSM.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cy_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  logic fa_s;
  logic fa_c;

  fulladder u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (cy_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // cy_q doubles as the carry-out once the last bit is processed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            cy_q    <= bus.c_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            sum_q <= {fa_s, sum_q[WIDTH-1:1]};
            cy_q  <= fa_c;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.ack) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sum_out = sum_q;
  assign bus.c_out   = cy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed vectors,
// expected results queued at issue, popped on each done rise.
module tb_serial_add_ctrl;

  logic clk;
  logic rst;

  int errors;
  int checks;
  int episodes;

  logic [8:0] exp_q[$];

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic       c,
                       input bit         push,
                       input logic [7:0] s_exp,
                       input logic       c_exp);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.c_in  = c;
    if (push) exp_q.push_back({c_exp, s_exp});
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_edges);
    int n;
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    chk(name, n, exp_edges);
  endtask

  task automatic release_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("idle_after_ack", {31'd0, bus.done}, 0);
  endtask

  // Monitor: compares each completed result against the queue
  initial begin
    logic       done_prev;
    logic [8:0] e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !done_prev) begin
        episodes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got %0h expected none",
                   {bus.c_out, bus.sum_out});
        end else begin
          e = exp_q.pop_front();
          if ({bus.c_out, bus.sum_out} !== e) begin
            errors++;
            $display("FAIL result: got %0h expected %0h",
                     {bus.c_out, bus.sum_out}, e);
          end
        end
      end
      done_prev = bus.done;
    end
  end

  initial begin
    int ep;
    errors    = 0;
    checks    = 0;
    episodes  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.c_in  = 1'b0;
    bus.abort = 1'b0;
    bus.ack   = 1'b0;
    #12;
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_sum", {24'd0, bus.sum_out}, 0);
    chk("rst_cout", {31'd0, bus.c_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // FF + 01 + 0 with ack held high
    bus.ack = 1'b1;
    issue(8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1);
    chk("busy_run", {31'd0, bus.busy}, 1);
    wait_done("latency_ff01", 8);
    chk("sum_ff01", {24'd0, bus.sum_out}, 32'h00);
    chk("cout_ff01", {31'd0, bus.c_out}, 1);
    tick();
    chk("idle_done", {31'd0, bus.done}, 0);
    chk("idle_busy", {31'd0, bus.busy}, 0);
    chk("hold_sum", {24'd0, bus.sum_out}, 32'h00);
    chk("hold_cout", {31'd0, bus.c_out}, 1);
    bus.ack = 1'b0;

    issue(8'h5A, 8'hA5, 1'b1, 1, 8'h00, 1'b1);
    wait_done("latency_5a", 8);
    chk("sum_5a", {24'd0, bus.sum_out}, 32'h00);
    chk("cout_5a", {31'd0, bus.c_out}, 1);
    release_ack();

    issue(8'h12, 8'h34, 1'b0, 1, 8'h46, 1'b0);
    wait_done("latency_12", 8);
    chk("sum_12", {24'd0, bus.sum_out}, 32'h46);
    chk("cout_12", {31'd0, bus.c_out}, 0);
    release_ack();

    // start pulses and operand changes during RUN are ignored
    ep = episodes;
    issue(8'h0F, 8'h01, 1'b0, 1, 8'h10, 1'b0);
    tick();
    tick();
    bus.start = 1'b1;
    bus.a_in  = 8'hFF;
    bus.b_in  = 8'hFF;
    bus.c_in  = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.a_in  = 8'hAA;
    bus.b_in  = 8'h55;
    tick();
    bus.start = 1'b0;
    wait_done("latency_restart", 3);
    chk("sum_restart", {24'd0, bus.sum_out}, 32'h10);
    chk("cout_restart", {31'd0, bus.c_out}, 0);
    release_ack();
    repeat (10) tick();
    chk("one_episode", episodes - ep, 1);

    // abort at RUN cycle 4
    ep = episodes;
    issue(8'h11, 8'h22, 1'b0, 0, 8'h00, 1'b0);
    repeat (3) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 0);
    chk("abort_done", {31'd0, bus.done}, 0);
    repeat (12) tick();
    chk("abort_no_done", episodes - ep, 0);
    issue(8'h80, 8'h80, 1'b1, 1, 8'h01, 1'b1);
    wait_done("latency_after_abort", 8);
    chk("sum_after_abort", {24'd0, bus.sum_out}, 32'h01);
    chk("cout_after_abort", {31'd0, bus.c_out}, 1);
    release_ack();

    // abort on the final-bit edge wins
    ep = episodes;
    issue(8'h01, 8'h01, 1'b0, 0, 8'h00, 1'b0);
    repeat (7) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_last_busy", {31'd0, bus.busy}, 0);
    chk("abort_last_done", {31'd0, bus.done}, 0);
    repeat (4) tick();
    chk("abort_last_none", episodes - ep, 0);

    // asynchronous reset mid-RUN
    ep = episodes;
    issue(8'h01, 8'h01, 1'b0, 0, 8'h00, 1'b0);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 0);
    chk("arst_done", {31'd0, bus.done}, 0);
    chk("arst_sum", {24'd0, bus.sum_out}, 0);
    chk("arst_cout", {31'd0, bus.c_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) tick();
    chk("arst_no_done", episodes - ep, 0);

    // DONE holds without ack; abort ignored; start+ack only exits
    issue(8'h33, 8'h44, 1'b0, 1, 8'h77, 1'b0);
    wait_done("latency_hold", 8);
    bus.abort = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_done", {31'd0, bus.done}, 1);
      chk("hold_sum77", {24'd0, bus.sum_out}, 32'h77);
      chk("hold_cout0", {31'd0, bus.c_out}, 0);
    end
    bus.abort = 1'b0;
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    bus.a_in  = 8'h01;
    bus.b_in  = 8'h01;
    tick();
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    chk("startack_busy", {31'd0, bus.busy}, 0);
    chk("startack_done", {31'd0, bus.done}, 0);
    tick();
    chk("startack_idle", {31'd0, bus.busy}, 0);
    chk("startack_sum", {24'd0, bus.sum_out}, 32'h77);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("episodes", episodes, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
